// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op encodings, FSM states, flag payload.
package alu_pkg;

    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_SUB   = 5'b00110;
    localparam logic [4:0] OP_SLL   = 5'b00111;
    localparam logic [4:0] OP_SRL   = 5'b01000;
    localparam logic [4:0] OP_SRA   = 5'b01001;
    localparam logic [4:0] OP_SLT   = 5'b01010;
    localparam logic [4:0] OP_SLTU  = 5'b01011;
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULHU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10100;
    localparam logic [4:0] OP_DIVU  = 5'b10101;
    localparam logic [4:0] OP_REM   = 5'b10110;
    localparam logic [4:0] OP_REMU  = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic sign;
        logic carry;
        logic overflow;
    } flags_t;

    // Width of the shift amount field for an n-bit datapath.
    function automatic int unsigned shamt_w(input int unsigned n);
        return $clog2(n);
    endfunction

    // Ops that go through the iterative multiply/divide engine.
    function automatic logic is_muldiv(input logic [4:0] op);
        case (op)
            OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one {hi,lo} accumulator.
// Runs exactly N steps after start; the final step's value is presented
// combinationally (with sign correction) on the cycle done_c_o is high.
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [2:0]   op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         done_c_o,
    output logic [N-1:0] res_c_o
);

    localparam int unsigned CW = shamt_w(N);

    logic          run_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  hi_q, lo_q, opd_q;
    logic          is_div_q, sel_hi_q, neg_q;

    logic [N-1:0]  hi_d, lo_d, res_raw;
    logic [N:0]    mul_sum, div_shift, div_trial;
    logic          signed_op;
    logic [N-1:0]  a_mag, b_mag;

    // Operand conditioning at start: magnitudes for signed divide.
    always_comb begin
        signed_op = op_i[2] && !op_i[0];
        a_mag     = (signed_op && a_i[N-1]) ? -a_i : a_i;
        b_mag     = (signed_op && b_i[N-1]) ? -b_i : b_i;
    end

    // One iteration step plus final result selection and sign fix-up.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {hi_q, lo_q[N-1]};
        div_trial = div_shift - {1'b0, opd_q};
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (is_div_q) begin
            if (!div_trial[N]) begin
                hi_d = div_trial[N-1:0];
                lo_d = {lo_q[N-2:0], 1'b1};
            end else begin
                hi_d = div_shift[N-1:0];
                lo_d = {lo_q[N-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[N:1];
            lo_d = {mul_sum[0], lo_q[N-1:1]};
        end
        res_raw  = sel_hi_q ? hi_d : lo_d;
        res_c_o  = neg_q ? -res_raw : res_raw;
        done_c_o = run_q && (cnt_q == CW'(N - 1));
    end

    // Accumulator, operand and iteration counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            sel_hi_q <= 1'b0;
            neg_q    <= 1'b0;
        end else if (start_i) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            hi_q     <= '0;
            is_div_q <= op_i[2];
            if (op_i[2]) begin
                lo_q     <= a_mag;
                opd_q    <= b_mag;
                sel_hi_q <= op_i[1];
                // Divide by zero keeps the all-ones quotient unnegated;
                // the remainder is |a| re-signed, which reproduces a.
                neg_q    <= op_i[1] ? (signed_op && a_i[N-1])
                                    : (signed_op && (a_i[N-1] ^ b_i[N-1]) && (b_i != '0));
            end else begin
                lo_q     <= b_i;
                opd_q    <= a_i;
                sel_hi_q <= op_i[0];
                neg_q    <= 1'b0;
            end
        end else if (run_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (done_c_o) begin
                run_q <= 1'b0;
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith/shift/compare ops plus an N-cycle
// multiply/divide engine, behind a valid/ready handshake on both sides.
module iter_alu
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero_flag,
    output logic         sign_flag,
    output logic         carry_flag,
    output logic         overflow_flag,
    output logic         busy
);

    localparam int unsigned SHW = shamt_w(N);
    localparam int unsigned NW  = N + 1;

    state_e       state_q, state_d;
    logic [N-1:0] result_q, result_d;
    flags_t       flags_q, flags_d;
    logic         out_valid_q, busy_q;

    logic           accept, md_start, md_done;
    logic [N-1:0]   md_res;
    logic [N-1:0]   b_eff, alu_res;
    logic [N:0]     sum;
    logic [SHW-1:0] shamt;
    logic           is_sub, alu_c, alu_v;

    iter_muldiv #(.N(N)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .op_i     (op[2:0]),
        .a_i      (a),
        .b_i      (b),
        .done_c_o (md_done),
        .res_c_o  (md_res)
    );

    // Handshake: accept in IDLE, or in DONE while the result is being taken.
    always_comb begin
        in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        accept   = in_valid && in_ready;
    end

    // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        is_sub  = (op == OP_SUB);
        b_eff   = is_sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + NW'(is_sub);
        shamt   = b[SHW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_ADD, OP_SUB: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_v   = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = N'($signed(a) >>> shamt);
            OP_SLT:  alu_res = N'($signed(a) < $signed(b));
            OP_SLTU: alu_res = N'(a < b);
            default: alu_res = '0;
        endcase
    end

    // Next-state, result and flag capture.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        md_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    if (is_muldiv(op)) begin
                        state_d  = ST_BUSY;
                        md_start = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        flags_d  = '{zero: (alu_res == '0), sign: alu_res[N-1],
                                     carry: alu_c, overflow: alu_v};
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d  = ST_DONE;
                    result_d = md_res;
                    flags_d  = '{zero: (md_res == '0), sign: md_res[N-1],
                                 carry: 1'b0, overflow: 1'b0};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_BUSY);
        end
    end

    assign out_valid     = out_valid_q;
    assign busy          = busy_q;
    assign result        = result_q;
    assign zero_flag     = flags_q.zero;
    assign sign_flag     = flags_q.sign;
    assign carry_flag    = flags_q.carry;
    assign overflow_flag = flags_q.overflow;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (N=32): vector table through a scoreboard,
// plus hand-written hold, back-to-back and reset-abort sequences.
module tb_iter_alu;

    localparam int unsigned N = 32;

    localparam logic [4:0] T_AND = 5'b00000, T_OR = 5'b00001, T_ADD = 5'b00010,
                           T_XOR = 5'b00100, T_SUB = 5'b00110, T_SLL = 5'b00111,
                           T_SRL = 5'b01000, T_SRA = 5'b01001, T_SLT = 5'b01010,
                           T_SLTU = 5'b01011, T_MUL = 5'b10000, T_MULHU = 5'b10001,
                           T_DIV = 5'b10100, T_DIVU = 5'b10101, T_REM = 5'b10110,
                           T_REMU = 5'b10111;

    logic         clk;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0]   op;
    logic [N-1:0] a, b, result;
    logic         zero_flag, sign_flag, carry_flag, overflow_flag;

    iter_alu #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op            (op),
        .a             (a),
        .b             (b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero_flag     (zero_flag),
        .sign_flag     (sign_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        v;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit md_op(input logic [4:0] o);
        return o inside {T_MUL, T_MULHU, T_DIV, T_DIVU, T_REM, T_REMU};
    endfunction

    // Present one op (out_ready high so a DONE result is taken in the same
    // cycle), scramble inputs while waiting, then check latency and output.
    task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] rv,
                          input logic cv, input logic vv, input bit rel);
        exp_t e;
        int   lat, busy_n, rdy_n, waitn;
        e.res = rv;
        e.flg = {(rv == 32'd0), rv[31], cv, vv};
        in_valid  = 1'b1;
        op        = o;
        a         = av;
        b         = bv;
        out_ready = 1'b1;
        #1;
        waitn = 0;
        while (!in_ready && waitn < 100) begin
            @(posedge clk); #1;
            waitn++;
        end
        if (waitn >= 100) check({name, " accept"}, 64'(in_ready), 64'd1);
        sb.push_back(e);
        @(posedge clk); #1;
        out_ready = 1'b0;
        lat = 1; busy_n = 0; rdy_n = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_n++;
            if (in_ready) rdy_n++;
            op = 5'($urandom);
            a  = $urandom;
            b  = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({name, " latency"}, 64'(lat), md_op(o) ? 64'd33 : 64'd1);
        check({name, " busy_cycles/ready_in_busy"}, {32'(busy_n), 32'(rdy_n)},
              {(md_op(o) ? 32'd32 : 32'd0), 32'd0});
        if (sb.size() == 0) begin
            check({name, " scoreboard"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            last_exp = e;
            check({name, " result"}, 64'(result), 64'(e.res));
            check({name, " flags zscv"},
                  64'({zero_flag, sign_flag, carry_flag, overflow_flag}), 64'(e.flg));
        end
        if (rel) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({name, " release valid/ready"}, 64'({out_valid, in_ready}), 64'b01);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_cnt;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;

        vecs.push_back('{"add_ovf",   T_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{"add_wrap",  T_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"sub_eq",    T_SUB,  32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"sub_borrow",T_SUB,  32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{"sub_ovf",   T_SUB,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1, 1'b1});
        vecs.push_back('{"and",       T_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0});
        vecs.push_back('{"or",        T_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0});
        vecs.push_back('{"xor",       T_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0});
        vecs.push_back('{"sll31",     T_SLL,  32'h00000001, 32'd31,       32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{"sll_mask",  T_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0});
        vecs.push_back('{"srl31",     T_SRL,  32'h80000000, 32'd31,       32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"sra4",      T_SRA,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0});
        vecs.push_back('{"slt",       T_SLT,  32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"sltu",      T_SLTU, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"undef_3",   5'b00011, 32'd5,      32'd5,        32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"undef_18",  5'b10010, 32'd5,      32'd5,        32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"mul_ff",    T_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"mulhu_ff",  T_MULHU,32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0});
        vecs.push_back('{"mul_x16",   T_MUL,  32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 1'b0});
        vecs.push_back('{"mulhu_x16", T_MULHU,32'h12345678, 32'h00000010, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"div_m7_2",  T_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0});
        vecs.push_back('{"rem_m7_2",  T_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{"div_7_m2",  T_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0});
        vecs.push_back('{"rem_7_m2",  T_REM,  32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"divu_9_0",  T_DIVU, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{"remu_9_0",  T_REMU, 32'd9,        32'd0,        32'h00000009, 1'b0, 1'b0});
        vecs.push_back('{"div_m9_0",  T_DIV,  32'hFFFFFFF7, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{"rem_m9_0",  T_REM,  32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 1'b0, 1'b0});
        vecs.push_back('{"div_min_m1",T_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{"rem_min_m1",T_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"divu_100_7",T_DIVU, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0});
        vecs.push_back('{"remu_100_7",T_REMU, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", 64'({out_valid, busy, in_ready, result,
                                     zero_flag, sign_flag, carry_flag, overflow_flag}),
              64'({1'b0, 1'b0, 1'b1, 32'h0, 4'h0}));
        rst = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].c, vecs[i].v, 1'b1);

        // Hold in DONE for 5 cycles, then take it while a new ADD is accepted.
        run_op("hold_add", T_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold stable", 64'({out_valid, in_ready, result,
                                       zero_flag, sign_flag, carry_flag, overflow_flag}),
                  64'({1'b1, 1'b0, last_exp.res, last_exp.flg}));
        end
        in_valid = 1'b1; op = T_ADD; a = 32'd10; b = 32'd20; out_ready = 1'b1;
        #1;
        check("no_bubble in_ready", 64'(in_ready), 64'd1);
        run_op("next_add", T_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b1);

        // DONE -> BUSY with no bubble.
        run_op("b2b_add", T_ADD, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0, 1'b0);
        run_op("b2b_mul", T_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 1'b1);

        // Reset during BUSY cycle 10 aborts the MUL with no result.
        in_valid = 1'b1; op = T_MUL; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; out_ready = 1'b1;
        #1;
        check("abort in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("abort busy before rst", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort after rst", 64'({out_valid, busy, in_ready, result,
                                       zero_flag, sign_flag, carry_flag, overflow_flag}),
              64'({1'b0, 1'b0, 1'b1, 32'h0, 4'h0}));
        ov_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) ov_cnt++;
        end
        check("abort no stale out_valid", 64'(ov_cnt), 64'd0);
        run_op("post_abort_mulhu", T_MULHU, 32'h80000000, 32'd4, 32'd2, 1'b0, 1'b0, 1'b1);

        check("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning datapath width; legal values are powers of two, 8 to 64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1, meaning op/a/b are presented.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts an operation this cycle.
REQ-006 The block SHALL have port op, input, 5, the operation select (encodings in REQ-012).
REQ-007 The block SHALL have ports a and b, input, N, the operands.
REQ-008 The block SHALL have port out_valid, output, 1, meaning result and flags are valid.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 The block SHALL have port result, output, N, the registered result.
REQ-011 The block SHALL have ports zero_flag, sign_flag, carry_flag and overflow_flag, output, 1 each, registered with result; it SHALL have port busy, output, 1, high in BUSY.

Function
REQ-012 Encodings SHALL be: 00000 AND, 00001 OR, 00010 ADD, 00110 SUB, 00100 XOR, 00111 SLL, 01000 SRL, 01001 SRA, 01010 SLT, 01011 SLTU, 10000 MUL (low N bits), 10001 MULHU (high N bits, unsigned), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
REQ-013 Any other encoding SHALL complete as a single-cycle operation with result 0.
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE; it SHALL reset to IDLE.
REQ-015 Acceptance SHALL occur when in_valid and in_ready are both high.
REQ-016 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready).
REQ-017 A single-cycle op (op[4]==0) accepted at edge k SHALL enter DONE with out_valid high after edge k.
REQ-018 A MUL/DIV-class op SHALL enter BUSY, iterate exactly N cycles, and enter DONE, giving out_valid high N+1 cycles after acceptance.
REQ-019 In DONE, result and flags SHALL stay stable until out_ready is high.
REQ-020 When out_ready is high in DONE and no new op is accepted, the FSM SHALL return to IDLE and drop out_valid.
REQ-021 When out_ready is high in DONE and a new op is accepted in the same cycle, the new op SHALL start with no bubble.
REQ-022 Shifts SHALL use b[log2(N)-1:0] as the amount; SRA SHALL replicate a[N-1].
REQ-023 SLT SHALL compare signed and SLTU unsigned; the result SHALL be 0 or 1.
REQ-024 SUB SHALL compute a + ~b + 1.
REQ-025 For ADD and SUB, carry_flag SHALL be the adder carry-out (SUB: 1 means no borrow) and overflow_flag SHALL be signed overflow.
REQ-026 For all other ops, carry_flag and overflow_flag SHALL be 0.
REQ-027 zero_flag SHALL be (result==0) and sign_flag SHALL be result[N-1], for all ops.
REQ-028 MUL SHALL use iterative shift-add of the 2N-bit product; DIV/REM SHALL use iterative restoring division on magnitudes, with sign correction at the BUSY->DONE transition.
REQ-029 The signed quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-030 For divide by zero, the quotient SHALL be all ones and the remainder SHALL be a.
REQ-031 For DIV of the most negative value by -1, the result SHALL be the most negative value; REM SHALL give 0.
REQ-032 Special cases SHALL keep the full N+1 latency (constant timing).
REQ-033 Operands SHALL be captured at acceptance; input changes during BUSY SHALL have no effect.
REQ-034 in_valid during BUSY SHALL be ignored (in_ready low).

Reset
REQ-035 While rst is high at an edge: state IDLE, out_valid 0, busy 0, result 0, all flags 0, iteration counter 0.
REQ-036 Resulting in_ready SHALL be 1.
REQ-037 Reset during BUSY or DONE SHALL abort the operation; no result SHALL ever be presented for it.

Structure
REQ-038 Shared package alu_pkg SHALL hold the op encodings, the FSM state enum, and the helper for shift width log2(N).
REQ-039 One sub-module, iter_muldiv, SHALL hold the shift-add/restoring datapath and the iteration counter, with start/done signalling.
REQ-040 The single-cycle ops and the FSM SHALL live in iter_alu.

Verification (N=32)
REQ-041 ADD 0x7FFFFFFF+0x00000001 -> 1 cycle: result 0x80000000, overflow 1, carry 0, sign 1, zero 0.
REQ-042 SUB 5-5 -> result 0, zero 1, carry 1. SRA 0x80000000 by 4 -> 0xF8000000. SLT 0xFFFFFFFF,1 -> 1. SLTU same -> 0.
REQ-043 MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULHU same -> 0xFFFFFFFE; out_valid exactly 33 cycles after accept, busy high 32 cycles.
REQ-044 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-045 out_ready low 5 cycles in DONE -> result/flags stable, in_ready 0; then out_ready high with a new ADD presented -> accepted that cycle, new result next cycle.
REQ-046 rst pulsed mid-MUL (cycle 10 of BUSY) -> next cycle: state IDLE, out_valid 0, busy 0, in_ready 1; no stale result ever asserted.
